rv_iopmp_mc_transaction_logic: RTL

- Multi-channel successor of the single-requester IOPMP transaction checker.
- Accepts up to NUM_CHANNELS concurrent requesters (e.g. AXI AR/AW per initiator) and arbitrates round-robin.
- For the granted request, scans the entry table window by window through an external match/decision array.
- Returns a per-channel allow/deny response under a valid/ready handshake and keeps a sticky first-error record with an overflow counter.

---
 rtl/rv_iopmp_pkg.sv | 21 ++
 rtl/rv_iopmp_mc_transaction_logic.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kind of a request and the sticky error capture record.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'd0,
    ACCESS_READ      = 2'd1,
    ACCESS_WRITE     = 2'd2,
    ACCESS_EXECUTION = 2'd3
  } access_t;

  typedef struct packed {
    logic        error_detected;
    logic [1:0]  ttype;
    logic [2:0]  etype;
    logic [31:0] sid;
    logic [15:0] eid;
    logic [31:0] err_reqaddr;
    logic [31:0] err_reqaddrh;
  } error_capture_t;

endpackage

// File: rtl/rv_iopmp_mc_transaction_logic.sv
// Multi-channel IOPMP transaction checker: round-robin grant, windowed entry scan,
// per-channel allow/deny response and a sticky first-error record.
//
//   state | meaning
//   IDLE  | pick next valid channel round-robin, latch its request
//   CHECK | scan entry windows through the external match array
//   RESP  | hold verdict on the granted channel until it is consumed
module rv_iopmp_mc_transaction_logic #(
  parameter int unsigned NUM_CHANNELS     = 2,
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned SID_WIDTH        = 8,
  parameter int unsigned NUMBER_ENTRIES   = 32,
  parameter int unsigned NUMBER_INSTANCES = 8,
  parameter int unsigned OFS_W            = $clog2(NUMBER_ENTRIES),
  localparam int unsigned NB_W            = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      iopmp_enabled_i,
  input  logic [NUM_CHANNELS-1:0]                   req_valid_i,
  output logic [NUM_CHANNELS-1:0]                   req_ready_o,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [NUM_CHANNELS*NB_W-1:0]              req_num_bytes_i,
  input  logic [NUM_CHANNELS*SID_WIDTH-1:0]         req_sid_i,
  input  rv_iopmp_pkg::access_t [NUM_CHANNELS-1:0]  req_access_i,
  output logic [NUM_CHANNELS-1:0]                   rsp_valid_o,
  input  logic [NUM_CHANNELS-1:0]                   rsp_ready_i,
  output logic                                      rsp_allow_o,
  output logic                                      chk_en_o,
  output logic [OFS_W-1:0]                          chk_offset_o,
  output logic [ADDR_WIDTH-1:0]                     chk_addr_o,
  output logic [NB_W-1:0]                           chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]                      chk_sid_o,
  output rv_iopmp_pkg::access_t                     chk_access_o,
  input  logic                                      chk_allow_i,
  input  logic                                      chk_err_i,
  input  logic [2:0]                                chk_err_type_i,
  input  logic [15:0]                               chk_err_eid_i,
  input  logic                                      err_clear_i,
  output rv_iopmp_pkg::error_capture_t              err_o,
  output logic [7:0]                                err_drop_cnt_o
);

  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(NUMBER_ENTRIES - NUMBER_INSTANCES);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, rr_q, rr_d;
  logic [OFS_W-1:0]             offset_q, offset_d;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [NB_W-1:0]              nb_q;
  logic [SID_WIDTH-1:0]         sid_q;
  rv_iopmp_pkg::access_t        access_q;
  logic                         allow_q, allow_d;

  logic                         grant_found;
  logic [CH_W-1:0]              grant_idx;
  int unsigned                  cand;
  logic                         latch;
  logic                         err_event;
  logic [2:0]                   err_type;
  logic [15:0]                  err_eid;
  logic [1:0]                   err_ttype;
  logic [63:0]                  addr_ext;
  rv_iopmp_pkg::error_capture_t err_q, err_new;
  logic [7:0]                   drop_q;

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      cand = (32'(rr_q) + i) % NUM_CHANNELS;
      if (!grant_found && req_valid_i[CH_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    offset_d    = offset_q;
    allow_d     = allow_q;
    latch       = 1'b0;
    err_event   = 1'b0;
    err_type    = 3'h0;
    err_eid     = 16'h0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    chk_en_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found && !rst_i) begin
          req_ready_o[grant_idx] = 1'b1;
          latch    = 1'b1;
          offset_d = '0;
          state_d  = CHECK;
          rr_d     = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      CHECK: begin
        chk_en_o = iopmp_enabled_i;
        if (!iopmp_enabled_i) begin
          allow_d = 1'b1;
          state_d = RESP;
        end else if (chk_err_i) begin
          allow_d   = 1'b0;
          err_event = 1'b1;
          err_type  = chk_err_type_i;
          err_eid   = chk_err_eid_i;
          state_d   = RESP;
        end else if (chk_allow_i) begin
          allow_d = 1'b1;
          state_d = RESP;
        end else if (offset_q == LAST_OFS) begin
          allow_d   = 1'b0;
          err_event = 1'b1;
          err_type  = 3'h5;
          state_d   = RESP;
        end else begin
          offset_d = offset_q + OFS_W'(NUMBER_INSTANCES);
        end
      end
      RESP: begin
        rsp_valid_o[ch_q] = 1'b1;
        if (rsp_ready_i[ch_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (access_q)
      rv_iopmp_pkg::ACCESS_WRITE:     err_ttype = 2'd2;
      rv_iopmp_pkg::ACCESS_EXECUTION: err_ttype = 2'd3;
      default:                        err_ttype = 2'd1;
    endcase
    addr_ext                    = 64'(addr_q);
    err_new                     = '0;
    err_new.error_detected      = 1'b1;
    err_new.ttype               = err_ttype;
    err_new.etype               = err_type;
    err_new.sid                 = 32'(sid_q);
    err_new.eid                 = err_eid;
    err_new.err_reqaddr         = addr_ext[31:0];
    err_new.err_reqaddrh        = addr_ext[63:32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      ch_q     <= '0;
      offset_q <= '0;
      allow_q  <= 1'b0;
      addr_q   <= '0;
      nb_q     <= '0;
      sid_q    <= '0;
      access_q <= rv_iopmp_pkg::ACCESS_NONE;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      offset_q <= offset_d;
      allow_q  <= allow_d;
      if (latch) begin
        ch_q     <= grant_idx;
        addr_q   <= req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        nb_q     <= req_num_bytes_i[grant_idx*NB_W +: NB_W];
        sid_q    <= req_sid_i[grant_idx*SID_WIDTH +: SID_WIDTH];
        access_q <= req_access_i[grant_idx];
      end
    end
  end

  // A clear coinciding with a new error leaves the new error recorded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      if (err_event && (err_clear_i || !err_q.error_detected)) err_q <= err_new;
      else if (err_clear_i)                                     err_q <= '0;
      if (err_clear_i)                                          drop_q <= '0;
      else if (err_event && err_q.error_detected && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
    end
  end

  assign rsp_allow_o     = (state_q == RESP) && allow_q;
  assign chk_offset_o    = offset_q;
  assign chk_addr_o      = addr_q;
  assign chk_num_bytes_o = nb_q;
  assign chk_sid_o       = sid_q;
  assign chk_access_o    = access_q;
  assign err_o           = err_q;
  assign err_drop_cnt_o  = drop_q;

endmodule
